// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, reset PC
// default, NOP encoding and the word-alignment helper.
package fetch_pkg;

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_WAIT  = 2'd1,
      S_HOLD  = 2'd2,
      S_DROP  = 2'd3
   } fetch_state_e;

   localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
   localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

   function automatic logic [31:0] align4(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch unit bus bundle: branch redirect, instruction memory port and the
// decode-side valid/ready presentation.
interface fetch_if;
   logic        is_branch;
   logic [3:0]  branch_type;
   logic [31:0] pc_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        flush;

   modport master (
      input  is_branch, branch_type, pc_target, imem_rvalid, imem_rdata, if_ready,
      output imem_req, imem_addr, if_valid, if_pc, if_instr, flush
   );

   modport slave (
      output is_branch, branch_type, pc_target, imem_rvalid, imem_rdata, if_ready,
      input  imem_req, imem_addr, if_valid, if_pc, if_instr, flush
   );
endinterface

// File: rtl/fetch_stats.sv
// Free-running event counters for the fetch unit (handshakes, redirects,
// discarded responses); cleared by rst and wrapping at 2^32.
module fetch_stats (
   input  logic        clk,
   input  logic        rst,
   input  logic        inc_fetch,
   input  logic        inc_redirect,
   input  logic        inc_drop,
   output logic [31:0] stat_fetch,
   output logic [31:0] stat_redirect,
   output logic [31:0] stat_drop
);

   always_ff @(posedge clk) begin
      if (rst) begin
         stat_fetch    <= '0;
         stat_redirect <= '0;
         stat_drop     <= '0;
      end else begin
         if (inc_fetch)    stat_fetch    <= stat_fetch + 32'd1;
         if (inc_redirect) stat_redirect <= stat_redirect + 32'd1;
         if (inc_drop)     stat_drop     <= stat_drop + 32'd1;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch FSM (FETCH/WAIT/HOLD/DROP) with branch
// redirect. Define FETCH_STATS_EN to add the stat_* counter outputs.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
   input  logic        clk,
   input  logic        rst,
`ifdef FETCH_STATS_EN
   output logic [31:0] stat_fetch,
   output logic [31:0] stat_redirect,
   output logic [31:0] stat_drop,
`endif
   fetch_if.master     fif
);

   fetch_state_e state_q, state_d;
   logic [31:0]  fetch_pc_q;
   logic [31:0]  if_pc_q;
   logic [31:0]  if_instr_q;
   logic         redirect;
   logic         take_rsp;

   assign redirect = fif.is_branch;
   assign take_rsp = (state_q == S_WAIT) && fif.imem_rvalid && !redirect;

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH: state_d = redirect ? S_FETCH : S_WAIT;
         // A response arriving with the redirect is consumed here, so DROP
         // would otherwise wait forever for a second one.
         S_WAIT: begin
            if (redirect)              state_d = fif.imem_rvalid ? S_FETCH : S_DROP;
            else if (fif.imem_rvalid)  state_d = S_HOLD;
         end
         S_HOLD:  if (redirect || fif.if_ready) state_d = S_FETCH;
         S_DROP:  if (fif.imem_rvalid) state_d = S_FETCH;
         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_FETCH;
         fetch_pc_q <= RESET_PC;
         if_pc_q    <= '0;
         if_instr_q <= NOP_INSTR;
      end else begin
         state_q <= state_d;
         if (redirect)      fetch_pc_q <= align4(fif.pc_target);
         else if (take_rsp) fetch_pc_q <= fetch_pc_q + 32'd4;
         if (take_rsp) begin
            if_pc_q    <= fetch_pc_q;
            if_instr_q <= fif.imem_rdata;
         end
      end
   end

   assign fif.imem_req  = (state_q == S_FETCH) && !redirect && !rst;
   assign fif.imem_addr = fetch_pc_q;
   assign fif.if_valid  = (state_q == S_HOLD) && !rst;
   assign fif.if_pc     = if_pc_q;
   assign fif.if_instr  = if_instr_q;
   assign fif.flush     = redirect;

`ifdef FETCH_STATS_EN
   fetch_stats u_stats (
      .clk          (clk),
      .rst          (rst),
      .inc_fetch    (fif.if_valid && fif.if_ready && !redirect),
      .inc_redirect (redirect),
      .inc_drop     ((state_q == S_DROP) && fif.imem_rvalid),
      .stat_fetch   (stat_fetch),
      .stat_redirect(stat_redirect),
      .stat_drop    (stat_drop)
   );
`endif

endmodule
